// File: rtl/lv1a_dispatcher_if.sv
// rtl/lv1a_dispatcher_if.sv - trigger/control inputs and serial/status outputs of the LV1A dispatcher
interface lv1a_dispatcher_if #(
  parameter int TAG_W   = 16,
  parameter int FIFO_AW = 3
);
  logic               in_lv1a;
  logic               in_live;
  logic               clr_evt_cnt;
  logic               in_busy;
  logic               out_trig_ser;
  logic               out_frame_act;
  logic [TAG_W-1:0]   out_evt_num;
  logic [FIFO_AW:0]   out_fifo_level;
  logic               out_ovf;
  logic [15:0]        out_drop_cnt;

  modport master (
    output in_lv1a, in_live, clr_evt_cnt, in_busy,
    input  out_trig_ser, out_frame_act, out_evt_num, out_fifo_level, out_ovf, out_drop_cnt
  );

  modport slave (
    input  in_lv1a, in_live, clr_evt_cnt, in_busy,
    output out_trig_ser, out_frame_act, out_evt_num, out_fifo_level, out_ovf, out_drop_cnt
  );
endinterface

// File: rtl/lv1a_dispatcher.sv
// rtl/lv1a_dispatcher.sv - tags LV1A pulses, queues tags and serializes them as framed trigger words
module lv1a_dispatcher #(
  parameter int TAG_W     = 16,
  parameter int FIFO_AW   = 3,
  parameter int FRAME_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  lv1a_dispatcher_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = $clog2(TAG_W + FRAME_GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   evt_q, evt_d;
  logic [TAG_W-1:0]   sr_q, sr_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        drop_q, drop_d;
  logic               trig_q, trig_d;
  logic               act_q, act_d;
  logic [TAG_W-1:0]   mem_q [DEPTH];

  logic               accept;
  logic               full;
  logic               push;
  logic               pop;
  logic [TAG_W-1:0]   tag_in;
  logic [TAG_W-1:0]   head;

  assign accept = bus.in_lv1a & bus.in_live;
  assign full   = (level_q == (FIFO_AW+1)'(DEPTH));
  // A pop on the same edge frees a slot, so a full FIFO still takes the new tag.
  assign push   = accept & (~full | pop);
  // A clear coinciding with an accept hands out tag 0.
  assign tag_in = bus.clr_evt_cnt ? '0 : evt_q;
  assign head   = mem_q[rd_ptr_q];

  // Event counter, sticky overflow and saturating drop counter.
  always_comb begin
    evt_d  = evt_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (bus.clr_evt_cnt) begin
      evt_d  = accept ? TAG_W'(1) : '0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (accept) begin
      evt_d = evt_q + TAG_W'(1);
      if (!push) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tag_in;
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Serializer next-state logic; busy only gates leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_START;
      S_START:  state_d = S_DATA;
      S_DATA:   if (cnt_q == CNT_W'(TAG_W - 1)) state_d = S_PARITY;
      S_PARITY: state_d = (FRAME_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:    if (cnt_q == CNT_W'(FRAME_GAP - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Serializer outputs: pop request and the line/frame-active values registered next edge.
  always_comb begin
    pop    = (state_q == S_IDLE) && (level_q != '0) && !bus.in_busy;
    trig_d = 1'b0;
    act_d  = 1'b0;
    case (state_q)
      S_START:  begin trig_d = 1'b1;            act_d = 1'b1; end
      S_DATA:   begin trig_d = sr_q[TAG_W-1];   act_d = 1'b1; end
      S_PARITY: begin trig_d = par_q;           act_d = 1'b1; end
      default:  begin trig_d = 1'b0;            act_d = 1'b0; end
    endcase
  end

  // Shift register, parity and bit/gap counter.
  always_comb begin
    sr_d  = sr_q;
    par_d = par_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (pop) begin
        sr_d  = head;
        par_d = ^head;
      end
      S_START:  cnt_d = '0;
      S_DATA: begin
        sr_d  = {sr_q[TAG_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_PARITY: cnt_d = '0;
      S_GAP:    cnt_d = cnt_q + CNT_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  // Datapath and status registers; reset also forces the line low mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q    <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      trig_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      evt_q    <= evt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      trig_q   <= trig_d;
      act_q    <= act_d;
    end
  end

  assign bus.out_trig_ser   = trig_q;
  assign bus.out_frame_act  = act_q;
  assign bus.out_evt_num    = evt_q;
  assign bus.out_fifo_level = level_q;
  assign bus.out_ovf        = ovf_q;
  assign bus.out_drop_cnt   = drop_q;
endmodule

// File: tb/tb_lv1a_dispatcher.sv
// tb/tb_lv1a_dispatcher.sv - scoreboard bench for lv1a_dispatcher against a queue-based model
module tb_lv1a_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lv1a_dispatcher_if bus ();

  lv1a_dispatcher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int PERIOD = 21;  // START + 16 DATA + PARITY + 2 GAP + 1 IDLE

  int     vectors = 0;
  int     errors  = 0;

  int     m_evt;
  int     m_q[$];
  int     m_drop;
  bit     m_ovf;
  longint edge_n = 0;
  longint m_free = 0;
  int     exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic chk_status();
    vectors++;
    if (bus.out_evt_num !== 16'(m_evt) || bus.out_fifo_level !== 4'(m_q.size()) ||
        bus.out_ovf !== m_ovf || bus.out_drop_cnt !== 16'(m_drop)) begin
      errors++;
      $display("FAIL status @edge %0d: got evt=%h lvl=%0d ovf=%0b drop=%0d, want evt=%h lvl=%0d ovf=%0b drop=%0d",
               edge_n, bus.out_evt_num, bus.out_fifo_level, bus.out_ovf, bus.out_drop_cnt,
               16'(m_evt), m_q.size(), m_ovf, m_drop);
    end
  endtask

  // Reference model of one clock edge: frames start at most once per PERIOD edges.
  task automatic model_step(input bit lv, input bit live, input bit clr, input bit busy);
    bit acc;
    int tag;
    acc = lv && live;
    if (edge_n >= m_free && m_q.size() > 0 && !busy) begin
      exp_q.push_back(m_q.pop_front());
      m_free = edge_n + PERIOD;
    end
    tag = clr ? 0 : m_evt;
    if (acc) begin
      if (m_q.size() < 8) m_q.push_back(tag);
      else if (!clr) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (clr) begin
      m_drop = 0;
      m_ovf  = 1'b0;
      m_evt  = acc ? 1 : 0;
    end else if (acc) begin
      m_evt = (m_evt + 1) % 65536;
    end
    edge_n++;
  endtask

  task automatic model_reset();
    m_evt  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_free = 0;
  endtask

  task automatic cyc(input bit lv, input bit live, input bit clr, input bit busy);
    bus.in_lv1a     = lv;
    bus.in_live     = live;
    bus.clr_evt_cnt = clr;
    bus.in_busy     = busy;
    model_step(lv, live, clr, busy);
    @(posedge clk);
    #1;
    chk_status();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_q.size() != 0 || edge_n < m_free) && n < 800) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("drain_done", {31'd0, (n < 800)}, 32'd1);
  endtask

  // Frame monitor: reassembles each frame from the line and checks it against the scoreboard.
  initial begin
    int   mon_cnt;
    logic [15:0] mon_tag;
    bit   act_bad;
    int   e;
    mon_cnt = 0;
    mon_tag = '0;
    act_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_cnt = 0;
      end else if (mon_cnt == 0) begin
        if (bus.out_trig_ser === 1'b1) begin
          mon_cnt = 1;
          mon_tag = '0;
          act_bad = (bus.out_frame_act !== 1'b1);
        end
      end else if (mon_cnt <= 16) begin
        mon_tag = {mon_tag[14:0], bus.out_trig_ser};
        if (bus.out_frame_act !== 1'b1) act_bad = 1'b1;
        mon_cnt++;
      end else begin
        if (bus.out_frame_act !== 1'b1) act_bad = 1'b1;
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame: got unexpected tag %h parity %b, want no frame", mon_tag, bus.out_trig_ser);
        end else begin
          e = exp_q.pop_front();
          if (mon_tag !== 16'(e) || bus.out_trig_ser !== ^(16'(e)) || act_bad) begin
            errors++;
            $display("FAIL frame: got tag %h parity %b act_ok %b, want tag %h parity %b act_ok 1",
                     mon_tag, bus.out_trig_ser, !act_bad, 16'(e), ^(16'(e)));
          end
        end
        mon_cnt = 0;
      end
    end
  end

  initial begin
    int busy_p;
    bus.in_lv1a     = 1'b0;
    bus.in_live     = 1'b0;
    bus.clr_evt_cnt = 1'b0;
    bus.in_busy     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {8'd0, bus.out_trig_ser, bus.out_frame_act, bus.out_evt_num, bus.out_fifo_level, bus.out_ovf},
        32'd0);
    chk("reset_drop", {16'd0, bus.out_drop_cnt}, 32'd0);
    rst_n = 1'b1;

    // Single LV1A: start bit appears two clocks after the accepting edge.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lat_edge0", {31'd0, bus.out_trig_ser}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lat_edge1", {31'd0, bus.out_trig_ser}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lat_start", {30'd0, bus.out_trig_ser, bus.out_frame_act}, 32'd3);
    drain();

    // Burst of 12: one popped immediately, 8 queued, 3 dropped.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("burst_drop", {16'd0, bus.out_drop_cnt}, 32'd3);
    chk("burst_ovf", {31'd0, bus.out_ovf}, 32'd1);
    chk("burst_level", {28'd0, bus.out_fifo_level}, 32'd8);
    drain();

    // Busy holds queued frames; releasing busy lets the next one start.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("busy_hold_act", {31'd0, bus.out_frame_act}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("busy_release_start", {31'd0, bus.out_trig_ser}, 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("busy_midframe_act", {31'd0, bus.out_frame_act}, 32'd1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Not live: pulses ignored. Clear with accept: tag 0, counter 1.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_with_accept", {16'd0, bus.out_evt_num}, 32'd1);
    drain();

    // Reset during DATA bit 5 drops the line at once.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_frame_act", {31'd0, bus.out_frame_act}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_abort", {30'd0, bus.out_trig_ser, bus.out_frame_act}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_status();

    // Randomized traffic with alternating busy-free and busy-heavy phases.
    for (int i = 0; i < 4000; i++) begin
      busy_p = ((i / 500) % 2 == 1) ? 35 : 0;
      cyc($urandom_range(99) < 40, $urandom_range(99) < 92, $urandom_range(999) < 5,
          $urandom_range(99) < busy_p);
    end
    drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
